debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_channel.sv | 105 ++++++++++
 rtl/debounce_bank.sv | 34 +++
 tb/tb_debounce_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default sizes for the debounce bank
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHK_HI = 2'b01,
        HIGH   = 2'b11,
        CHK_LO = 2'b10
    } state_t;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 16;

    function automatic logic level_of(input state_t st);
        return (st == HIGH) || (st == CHK_LO);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce channel (FSM, counter, pulses)
// DEBOUNCE_BANK_SYNC_EN adds a 2-flop input synchroniser ahead of the FSM
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             deb_out,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    logic s;

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign s = sync_q[1];
`else
    assign s = din;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_d;

    // Compare uses >= so a limit lowered below cnt commits on the next sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = CHK_HI;
                        cnt_d   = '0;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (cnt_q >= limit) begin
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_d = CHK_LO;
                        cnt_d   = '0;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_d = HIGH;
                    end else if (cnt_q >= limit) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        deb_d = level_of(state_d);
    end

    // A disable drops the level silently, hence fall is gated by en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            deb_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            deb_out    <= deb_d;
            rise_pulse <= deb_d & ~deb_out;
            fall_pulse <= ~deb_d & deb_out & en;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of NCH independent debounce channels
// DEBOUNCE_BANK_SYNC_EN enables per-channel input synchronisers
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   din,
    input  logic [NCH-1:0]   ch_en,
    input  logic [CNT_W-1:0] limit,
    output logic [NCH-1:0]   deb_out,
    output logic [NCH-1:0]   rise_pulse,
    output logic [NCH-1:0]   fall_pulse
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (din[i]),
            .en        (ch_en[i]),
            .limit     (limit),
            .deb_out   (deb_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - randomized self-checking bench for debounce_bank
// honours DEBOUNCE_BANK_SYNC_EN in its reference model
module tb_debounce_bank;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
`ifdef DEBOUNCE_BANK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   din;
    logic [NCH-1:0]   ch_en;
    logic [CNT_W-1:0] limit;
    logic [NCH-1:0]   deb_out, rise_pulse, fall_pulse;

    always #5 clk = ~clk;

    debounce_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .ch_en     (ch_en),
        .limit     (limit),
        .deb_out   (deb_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    // Model: a level commits once limit+2 consecutive samples differ from it
    int             run [NCH];
    logic [NCH-1:0] lvl, exp_rise, exp_fall, s1, s2;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        lvl = '0; exp_rise = '0; exp_fall = '0; s1 = '0; s2 = '0;
        for (int i = 0; i < NCH; i++) run[i] = 0;
    endtask

    task automatic model_update();
        logic [NCH-1:0] s;
`ifdef DEBOUNCE_BANK_SYNC_EN
        s  = s2;
        s2 = s1;
        s1 = din;
`else
        s = din;
`endif
        exp_rise = '0;
        exp_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i]) begin
                lvl[i] = 1'b0;
                run[i] = 0;
            end else if (s[i] != lvl[i]) begin
                run[i]++;
                if (run[i] >= int'(limit) + 2) begin
                    lvl[i] = s[i];
                    run[i] = 0;
                    if (s[i]) exp_rise[i] = 1'b1;
                    else      exp_fall[i] = 1'b1;
                end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_eq("deb_out", deb_out, lvl);
        check_eq("rise_pulse", rise_pulse, exp_rise);
        check_eq("fall_pulse", fall_pulse, exp_fall);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_deb", deb_out, 0);
        check_eq("rst_rise", rise_pulse, 0);
        check_eq("rst_fall", fall_pulse, 0);
        @(posedge clk);
        #1;
        check_eq("rst_hold", {deb_out, rise_pulse, fall_pulse}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; ch_en = '1; limit = 16'd3;
        model_reset();
        #12;
        check_eq("reset_state", {deb_out, rise_pulse, fall_pulse}, 0);
        rst_n = 1'b1;
        steps(2);

        // ch0 held high: rises on the (limit+2+LAT)th edge
        din[0] = 1'b1;
        steps(4 + LAT);
        check_eq("ch0_not_yet", deb_out[0], 0);
        step();
        check_eq("ch0_rise_deb", deb_out[0], 1);
        check_eq("ch0_rise_pulse", rise_pulse[0], 1);
        step();
        check_eq("ch0_rise_once", rise_pulse[0], 0);
        steps(4);

        // 3-cycle glitch on ch1 must not commit
        din[1] = 1'b1; steps(3);
        din[1] = 1'b0; steps(3 + LAT);
        check_eq("ch1_glitch", deb_out[1], 0);

        // limit=0: single low sample is filtered, two commit
        limit = 16'd0;
        din[0] = 1'b0; step();
        din[0] = 1'b1; steps(3 + LAT);
        check_eq("lim0_glitch", deb_out[0], 1);
        din[0] = 1'b0; steps(1 + LAT);
        step();
        check_eq("lim0_fall_pulse", fall_pulse[0], 1);
        check_eq("lim0_fall_deb", deb_out[0], 0);

        // limit lowered from 10 to 2 while cnt=5 commits on the next sample
        limit = 16'd10;
        din[3] = 1'b1; steps(6 + LAT);
        check_eq("lim_chg_wait", deb_out[3], 0);
        limit = 16'd2;
        step();
        check_eq("lim_chg_commit", deb_out[3], 1);

        // drop ch_en[2] while HIGH: silent clear
        limit = 16'd3;
        din[2] = 1'b1; steps(6 + LAT);
        check_eq("ch2_high", deb_out[2], 1);
        ch_en[2] = 1'b0;
        step();
        check_eq("ch2_dis_deb", deb_out[2], 0);
        check_eq("ch2_dis_fall", fall_pulse[2], 0);
        ch_en[2] = 1'b1;
        steps(6 + LAT);

        // reset mid CHK_LO on ch3
        din[3] = 1'b0; steps(2 + LAT);
        do_reset();
        steps(8);

        // all channels rise together
        din = '0; steps(6 + LAT);
        din = '1; steps(4 + LAT);
        step();
        check_eq("all_rise", rise_pulse, 4'hf);

        // randomized run
        for (int c = 0; c < 3000; c++) begin
            logic [NCH-1:0] flip;
            for (int i = 0; i < NCH; i++) flip[i] = ($urandom_range(0, 5) == 0);
            din = din ^ flip;
            if ($urandom_range(0, 39) == 0) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) limit = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
